rr_frame_arbiter4: RTL and testbench
====================================

Name: rr_frame_arbiter4

Overview:
Round-robin, frame-locked arbiter for one switch egress port. It grants one of four ingress ports and produces the one-hot select that drives the downstream 4:1 egress data mux. It gates the valid/ready handshake so that exactly one ingress frame streams to the egress at a time. The grant is held from first beat to last beat of a frame, and a watchdog releases a stalled grant.

Parameters:
TIMEOUT, 1024, cycles in LOCKED with no completed beat before forced release; 0 disables the watchdog.
CNT_W, $clog2(TIMEOUT+1), width of the watchdog counter (derived, not overridden).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req  in  4  per-ingress request: frame pending, first beat available.
in_valid  in  4  per-ingress beat valid.
in_last  in  4  per-ingress last beat of frame (qualified by in_valid).
in_ready  out  4  per-ingress ready; only the granted bit may be 1.
out_valid  out  1  egress beat valid.
out_ready  in  1  egress ready from the downstream stage.
grant  out  4  registered one-hot grant, or 0 when idle; drives the mux select.
busy  out  1  1 while in LOCKED.
timeout_err  out  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, grant=4'b0000, ptr=3 (port 0 has highest priority next), watchdog count=0, timeout_err=0. Reset applied mid-frame clears grant immediately, without waiting for a clock edge.
- Combinational outputs:
  - out_valid = |(grant & in_valid).
  - in_ready = grant & {4{out_ready}}.
  - busy = (state==LOCKED).
  - With grant=0: out_valid=0 and in_ready=0.
- Beat: a beat completes when out_valid & out_ready.
- Last: the current beat is the last beat when the beat completes and |(grant & in_last).
- Pick function: rotate priority starting at ptr+1 mod 4; take the first set bit of req; the result is one-hot or zero.
- IDLE:
  - If req != 0, register grant=pick(req, ptr) and go to LOCKED.
  - Latency is 1 cycle from req sampled to grant visible.
  - Otherwise stay in IDLE.
- LOCKED:
  - Grant is held regardless of req deasserting; req is only consulted at arbitration.
  - On a last beat:
    - ptr = index of current grant.
    - If req with the current port masked off is nonzero, grant = pick(that masked req, new ptr) and stay in LOCKED (zero-bubble handover).
    - Otherwise grant=0 and go to IDLE.
    - The current winner is always excluded at handover, even if it requests again.
  - On a non-last beat: no change to grant.
- Watchdog, LOCKED only:
  - Count increments each cycle with no completed beat and clears on every completed beat.
  - When count==TIMEOUT-1 and no beat completes that cycle, next cycle: grant=0, state=IDLE, timeout_err=1 for one cycle, ptr = index of the timed-out port, count=0.
  - TIMEOUT=0: counter held at 0, timeout_err never asserts.
- Simultaneous events: a last beat and the timeout in the same cycle are treated as a normal last beat (no timeout_err).
- ptr wraps 3 -> 0.
- Invariants:
  - grant is $onehot0 at all times.
  - in_ready is a subset of grant.
  - grant only changes on IDLE exit, last beat, timeout, or reset.

Decomposition:
- Package switch_arb_pkg:
  - localparam NUM_PORTS=4.
  - typedef logic [NUM_PORTS-1:0] port_oh_t.
  - typedef logic [1:0] port_idx_t.
  - typedef enum logic {IDLE, LOCKED} arb_state_t.
  - Functions oh2idx and idx2oh.
- Sub-module rr_pick4: purely combinational rotate-priority picker.
  - Inputs: req (port_oh_t), ptr (port_idx_t).
  - Output: one-hot grant_next.
  - Reused by future ingress-side arbiters.

Test Plan:
- Reset, then req=4'b1111 held, each frame 3 beats, out_ready=1 -> grants 0001,0010,0100,1000,0001 in order with zero-cycle gaps; first grant 1 cycle after req; ptr wraps.
- Port 2 grant, in_valid[2]=1 but out_ready=0 for 5 cycles, then 1 -> in_ready=0, out_valid=1 throughout stall; grant holds 0100; beats resume without loss.
- Frame on port 1 in progress, req drops to 0 mid-frame and req[3] rises -> grant stays 0010 until in_last[1] beat, then 1000 next cycle.
- TIMEOUT=8, port 0 granted with in_valid[0]=0 for 8 cycles -> grant=0000 and timeout_err=1 on the following cycle; next arbitration with req=4'b0011 grants 0010.
- Last beat in the same cycle the watchdog would expire -> normal handover, timeout_err stays 0.
- rst_n pulled low mid-frame, asynchronously between edges -> grant, in_ready and out_valid go 0 immediately; after release with req=4'b1000 the first grant is 1000, and with req=4'b1001 it is 0001.

Source files
------------

// File: rtl/switch_arb_pkg.sv
// Shared types and helpers for the switch egress/ingress arbiters.
package switch_arb_pkg;

  localparam int unsigned NUM_PORTS = 4;

  typedef logic [NUM_PORTS-1:0] port_oh_t;
  typedef logic [1:0]           port_idx_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // One-hot to index; a zero vector maps to index 0.
  function automatic port_idx_t oh2idx(input port_oh_t oh);
    port_idx_t idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (oh[i]) idx = port_idx_t'(i);
    end
    return idx;
  endfunction

  function automatic port_oh_t idx2oh(input port_idx_t idx);
    return port_oh_t'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotate-priority picker: first set req bit starting at ptr+1.
module rr_pick4
  import switch_arb_pkg::*;
(
  input  port_oh_t  req,
  input  port_idx_t ptr,
  output port_oh_t  grant_next
);

  always_comb begin
    logic      found;
    port_idx_t idx;
    grant_next = '0;
    found      = 1'b0;
    idx        = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      idx = port_idx_t'(32'(ptr) + k);
      if (!found && req[idx]) begin
        grant_next = idx2oh(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_frame_arbiter4.sv
// Round-robin, frame-locked 4-port egress arbiter with a stall watchdog.
module rr_frame_arbiter4
  import switch_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] in_valid,
  input  logic [NUM_PORTS-1:0] in_last,
  output logic [NUM_PORTS-1:0] in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic        WD_EN = (TIMEOUT != 0);

  arb_state_t       state_q, state_d;
  port_oh_t         grant_q, grant_d;
  port_idx_t        ptr_q,   ptr_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             terr_q,  terr_d;

  port_oh_t  pick_idle;
  port_oh_t  pick_hand;
  port_idx_t cur_idx;
  logic      beat;
  logic      last_beat;
  logic      wd_expire;

  // Fresh arbitration from IDLE uses the stored pointer.
  rr_pick4 u_pick_idle (
    .req        (req),
    .ptr        (ptr_q),
    .grant_next (pick_idle)
  );

  // Handover excludes the current winner and rotates from it.
  rr_pick4 u_pick_hand (
    .req        (req & ~grant_q),
    .ptr        (cur_idx),
    .grant_next (pick_hand)
  );

  assign cur_idx   = oh2idx(grant_q);
  assign out_valid = |(grant_q & in_valid);
  assign in_ready  = grant_q & {NUM_PORTS{out_ready}};
  assign beat      = out_valid & out_ready;
  assign last_beat = beat & (|(grant_q & in_last));

  if (TIMEOUT == 0) begin : g_no_wd
    assign wd_expire = 1'b0;
  end else begin : g_wd
    assign wd_expire = (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= port_idx_t'(NUM_PORTS - 1);
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  // Next-state: a last beat outranks a simultaneous watchdog expiry.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    terr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|req) begin
          grant_d = pick_idle;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (last_beat) begin
          ptr_d   = cur_idx;
          cnt_d   = '0;
          grant_d = pick_hand;
          if (pick_hand == '0) state_d = IDLE;
        end else if (beat) begin
          cnt_d = '0;
        end else if (wd_expire) begin
          grant_d = '0;
          state_d = IDLE;
          ptr_d   = cur_idx;
          cnt_d   = '0;
          terr_d  = 1'b1;
        end else if (WD_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign grant       = grant_q;
  assign busy        = (state_q == LOCKED);
  assign timeout_err = terr_q;

  ast_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant_q));
  ast_ready_subset: assert property (@(posedge clk) disable iff (!rst_n)
    ((in_ready & ~grant_q) == '0));
  ast_busy_grant: assert property (@(posedge clk) disable iff (!rst_n)
    (busy == (grant_q != '0)));

endmodule

// File: tb/tb_rr_frame_arbiter4.sv
// Self-checking bench for rr_frame_arbiter4: vector table, directed corners, random vs model.
module tb_rr_frame_arbiter4;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, in_valid, in_last, in_ready, grant;
  logic       out_valid, out_ready, busy, timeout_err;

  int checks   = 0;
  int failures = 0;

  // Reference state: granted port (-1 idle), priority pointer, stall count, error pulse.
  int m_g, m_ptr, m_cnt;
  bit m_terr;

  rr_frame_arbiter4 #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] iv;
    logic [3:0] il;
    logic       ordy;
    logic [3:0] g;
    logic       ov;
    logic [3:0] ir;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (p + k) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] oh(input int g);
    return (g < 0) ? 4'b0000 : 4'(1 << g);
  endfunction

  task automatic model_reset();
    m_g = -1; m_ptr = 3; m_cnt = 0; m_terr = 1'b0;
  endtask

  // Compare every output against the model, away from the rising edge.
  task automatic sample();
    logic ov_e;
    @(negedge clk);
    ov_e = (m_g >= 0) ? in_valid[m_g] : 1'b0;
    chk("grant", grant, oh(m_g));
    chk("out_valid", out_valid, ov_e);
    chk("in_ready", in_ready, out_ready ? oh(m_g) : 4'b0000);
    chk("busy", busy, m_g >= 0);
    chk("timeout_err", timeout_err, m_terr);
    chk("grant_onehot0", $onehot0(grant), 1);
  endtask

  task automatic advance();
    int ng, np, nc;
    bit nt, bt, lt;
    ng = m_g; np = m_ptr; nc = m_cnt; nt = 1'b0;
    bt = (m_g >= 0) ? (in_valid[m_g] && out_ready) : 1'b0;
    lt = bt && in_last[m_g];
    if (m_g < 0) begin
      nc = 0;
      if (req != 0) ng = pick(req, m_ptr);
    end else if (lt) begin
      np = m_g; nc = 0;
      ng = pick(req & ~oh(m_g), m_g);
    end else if (bt) begin
      nc = 0;
    end else if (m_cnt == TMO - 1) begin
      ng = -1; np = m_g; nc = 0; nt = 1'b1;
    end else begin
      nc = m_cnt + 1;
    end
    @(posedge clk);
    m_g = ng; m_ptr = np; m_cnt = nc; m_terr = nt;
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 0; in_valid = 0; in_last = 0; out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 14; i++) begin
      tbl[i].req  = 4'b1111;
      tbl[i].iv   = 4'b1111;
      tbl[i].ordy = 1'b1;
      tbl[i].il   = (i > 0 && (i % 3) == 0) ? 4'b1111 : 4'b0000;
      tbl[i].g    = (i == 0) ? 4'b0000 : 4'(1 << (((i - 1) / 3) % 4));
      tbl[i].ov   = (tbl[i].g != 0);
      tbl[i].ir   = tbl[i].g;
    end

    // Round robin across all ports, 3-beat frames, zero-bubble handovers.
    do_reset();
    chk("reset_grant", grant, 4'b0000);
    chk("reset_busy", busy, 1'b0);
    for (int i = 0; i < 14; i++) begin
      req = tbl[i].req; in_valid = tbl[i].iv; in_last = tbl[i].il; out_ready = tbl[i].ordy;
      sample();
      chk("tbl_grant", grant, tbl[i].g);
      chk("tbl_out_valid", out_valid, tbl[i].ov);
      chk("tbl_in_ready", in_ready, tbl[i].ir);
      advance();
    end

    // Egress stall on port 2 holds the grant and drops ready.
    do_reset();
    req = 4'b0100; cyc();
    req = 0; in_valid = 4'b0100; out_ready = 0;
    repeat (5) begin
      sample();
      chk("stall_in_ready", in_ready, 4'b0000);
      chk("stall_out_valid", out_valid, 1'b1);
      chk("stall_grant", grant, 4'b0100);
      advance();
    end
    out_ready = 1;
    cyc(); cyc();
    in_last = 4'b0100; cyc();
    in_last = 0; in_valid = 0;
    sample();
    chk("stall_done_grant", grant, 4'b0000);
    advance();

    // Request changes mid-frame do not move the grant until the last beat.
    do_reset();
    req = 4'b0010; cyc();
    req = 0; in_valid = 4'b0010; out_ready = 1; cyc();
    req = 4'b1000; cyc();
    in_last = 4'b0010;
    sample();
    chk("drop_hold_grant", grant, 4'b0010);
    advance();
    in_last = 0; in_valid = 0;
    sample();
    chk("drop_next_grant", grant, 4'b1000);
    advance();

    // Watchdog release after TMO idle cycles, then arbitration resumes past port 0.
    do_reset();
    req = 4'b0001; out_ready = 1; cyc();
    req = 0;
    repeat (TMO) begin
      sample();
      chk("wd_hold_grant", grant, 4'b0001);
      chk("wd_no_err", timeout_err, 1'b0);
      advance();
    end
    sample();
    chk("wd_grant", grant, 4'b0000);
    chk("wd_err", timeout_err, 1'b1);
    req = 4'b0011;
    advance();
    sample();
    chk("wd_rearb_grant", grant, 4'b0010);
    chk("wd_err_pulse", timeout_err, 1'b0);
    advance();

    // Last beat on the expiry cycle is an ordinary handover.
    do_reset();
    req = 4'b0001; out_ready = 1; cyc();
    req = 0;
    repeat (TMO - 1) cyc();
    in_valid = 4'b0001; in_last = 4'b0001; req = 4'b0010;
    cyc();
    in_valid = 0; in_last = 0; req = 0;
    sample();
    chk("race_grant", grant, 4'b0010);
    chk("race_no_err", timeout_err, 1'b0);
    advance();

    // Asynchronous reset mid-frame clears outputs without a clock edge.
    do_reset();
    req = 4'b0001; in_valid = 4'b0001; out_ready = 1; cyc();
    req = 0;
    sample();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_grant", grant, 4'b0000);
    chk("arst_in_ready", in_ready, 4'b0000);
    chk("arst_out_valid", out_valid, 1'b0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = 0;
    req = 4'b1000; cyc();
    req = 0;
    sample();
    chk("arst_first_1000", grant, 4'b1000);
    advance();
    do_reset();
    req = 4'b1001; cyc();
    req = 0;
    sample();
    chk("arst_first_1001", grant, 4'b0001);
    advance();

    // Randomized traffic with periodic egress stalls against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req       = 4'($urandom);
      in_valid  = 4'($urandom) | 4'($urandom);
      in_last   = 4'($urandom) & 4'($urandom);
      out_ready = ((c % 200) < 20) ? 1'b0 : ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
